dmem_arbiter: RTL

Two-port arbiter sharing the single-port data memory between the CPU load/store port (port 0) and a secondary master such as a DMA or loader (port 1). It sits between the CPU's `dataAddress`/`dataOut`/`dataWrEn`/`dataIn` signals and the data RAM. Ownership is registered, so a master keeps the memory for back-to-back accesses. A hold counter bounds how long one master may starve the other. Read data comes back through a registered valid pulse per port.

---
 rtl/dmem_arb_pkg.sv | 15 +
 rtl/dmem_arbiter_if.sv | 49 ++++
 rtl/dmem_arb_hold_cnt.sv | 31 +++
 rtl/dmem_arbiter.sv | 138 +++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-memory arbiter
// Purpose: ownership state enum and port index constants.
// Ports: none (package).
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - request/grant and memory bus bundle for the arbiter
// Purpose: groups both requester ports and the RAM-side bus.
// Ports (signals): pN_req/pN_we/pN_addr/pN_wdata from requesters, pN_gnt/pN_rvalid
//   and shared rdata back to them; mem_en/mem_we/mem_addr/mem_wdata to the RAM,
//   mem_rdata from the RAM. Modport slave is the arbiter side, master the environment.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);

  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_gnt;
  logic              p0_rvalid;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_gnt;
  logic              p1_rvalid;

  logic [DATA_W-1:0] rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  mem_rdata,
    output p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output mem_rdata,
    input  p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/dmem_arb_hold_cnt.sv
// rtl/dmem_arb_hold_cnt.sv - consecutive-access counter bounding owner tenure
// Purpose: counts owner accesses while the other port waits; flags the last allowed one.
// Ports: clk, nRst (sync active-low), clear, incr in; expire out (count == MAX_HOLD-1).
module dmem_arb_hold_cnt #(
  parameter int MAX_HOLD = 8
) (
  input  logic clk,
  input  logic nRst,
  input  logic clear,
  input  logic incr,
  output logic expire
);

  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] LAST = CW'(MAX_HOLD - 1);

  logic [CW-1:0] count_q;

  // No saturation: the forced handover on expire clears the count first.
  always_ff @(posedge clk) begin
    if (!nRst)
      count_q <= '0;
    else if (clear)
      count_q <= '0;
    else if (incr)
      count_q <= count_q + 1'b1;
  end

  assign expire = (count_q == LAST);

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter for the single-port data RAM
// Purpose: registered ownership FSM (IDLE/OWN0/OWN1), owner mux to RAM, per-port
//   registered read-valid. Port 0 is the CPU, port 1 the auxiliary master.
// Ports: clk, nRst (sync active-low), bus (dmem_arbiter_if.slave).
// Build option: DMEM_ARB_RR_EN selects least-recently-granted tie-break in IDLE;
//   undefined gives port 0 fixed priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input logic           clk,
  input logic           nRst,
  dmem_arbiter_if.slave bus
);

  arb_state_e state_q, state_d;
  logic gnt0, gnt1;
  logic req_y;
  logic expire;
  logic hold_clear;
  logic access;
  logic tie_to_aux;
  logic p0_rvalid_q, p1_rvalid_q;

  assign gnt0 = (state_q == OWN0);
  assign gnt1 = (state_q == OWN1);
  assign access = (gnt0 & bus.p0_req) | (gnt1 & bus.p1_req);

`ifdef DMEM_ARB_RR_EN
  logic last_q;

  // Resets to the aux port so the first tie goes to the CPU.
  always_ff @(posedge clk) begin
    if (!nRst)
      last_q <= PORT_AUX;
    else if (state_d != state_q) begin
      if (state_d == OWN0)
        last_q <= PORT_CPU;
      else if (state_d == OWN1)
        last_q <= PORT_AUX;
    end
  end

  assign tie_to_aux = (last_q == PORT_CPU);
`else
  assign tie_to_aux = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!nRst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.p0_req && bus.p1_req)
          state_d = tie_to_aux ? OWN1 : OWN0;
        else if (bus.p0_req)
          state_d = OWN0;
        else if (bus.p1_req)
          state_d = OWN1;
      end
      OWN0: begin
        if (!bus.p0_req)
          state_d = bus.p1_req ? OWN1 : IDLE;
        else if (bus.p1_req && expire)
          state_d = OWN1;
      end
      OWN1: begin
        if (!bus.p1_req)
          state_d = bus.p0_req ? OWN0 : IDLE;
        else if (bus.p0_req && expire)
          state_d = OWN0;
      end
      default: state_d = IDLE;
    endcase
  end

  // The count only matters while the non-owner is actually waiting.
  always_comb begin
    req_y = 1'b0;
    if (gnt0)
      req_y = bus.p1_req;
    else if (gnt1)
      req_y = bus.p0_req;
  end

  assign hold_clear = (state_d != state_q) || !req_y;

  dmem_arb_hold_cnt #(.MAX_HOLD(MAX_HOLD)) u_hold_cnt (
    .clk    (clk),
    .nRst   (nRst),
    .clear  (hold_clear),
    .incr   (access),
    .expire (expire)
  );

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (gnt0) begin
      bus.mem_en    = bus.p0_req;
      bus.mem_we    = bus.p0_req & bus.p0_we;
      bus.mem_addr  = bus.p0_addr;
      bus.mem_wdata = bus.p0_wdata;
    end else if (gnt1) begin
      bus.mem_en    = bus.p1_req;
      bus.mem_we    = bus.p1_req & bus.p1_we;
      bus.mem_addr  = bus.p1_addr;
      bus.mem_wdata = bus.p1_wdata;
    end
  end

  // RAM is synchronous, so read data appears the cycle after the access edge.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
    end else begin
      p0_rvalid_q <= gnt0 & bus.p0_req & ~bus.p0_we;
      p1_rvalid_q <= gnt1 & bus.p1_req & ~bus.p1_we;
    end
  end

  assign bus.p0_gnt    = gnt0;
  assign bus.p1_gnt    = gnt1;
  assign bus.p0_rvalid = p0_rvalid_q;
  assign bus.p1_rvalid = p1_rvalid_q;
  assign bus.rdata     = bus.mem_rdata;

endmodule
